// File: rtl/fu_alu_pipe_pkg.sv
// fu_alu_pipe_pkg
//   Shared encodings for the integer ALU functional unit: ALU opcodes,
//   including the MIN/MAX group, operand select codes, and width helpers
//   for the credit counter and the FIFO pointers.
//   The completion entry type (rob_id, rd_phy, rd_arch, rd_value) depends
//   on the unit's parameters, so it is declared inside fu_alu_pipe.
package fu_alu_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_MIN  = 4'd10,
    ALU_MAX  = 4'd11,
    ALU_MINU = 4'd12,
    ALU_MAXU = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_ZERO = 2'd1,
    OP1_PC   = 2'd2
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_ZERO = 2'd1,
    OP2_IMM  = 2'd2
  } op2_sel_e;

  // Width needed to hold an occupancy count from 0 to depth inclusive.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a circular buffer. It is at least one bit so that
  // depth 1 still gets a legal vector.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fu_alu_pipe_if.sv
// fu_alu_pipe_if
//   This interface joins the issue side (int RS issue register) and the
//   completion side (CDB arbiter) of the ALU functional unit.
//   - slave  : the functional unit. It receives in_* and cdb_grant, and
//              drives in_ready and cdb_*.
//   - master : the environment (RS plus arbiter), with the opposite
//              directions.
//
// Handshake semantics:
//   - Issue: an op transfers on a cycle where in_valid && in_ready.
//     in_ready is computed without reference to in_valid. The issuer may
//     present or withdraw in_valid at any time.
//   - CDB: the head entry transfers on a cycle where cdb_valid && cdb_grant.
//     While cdb_valid is high, the payload is held stable until it is
//     granted. A grant while cdb_valid is low has no effect.
interface fu_alu_pipe_if #(
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 5,
  parameter int PRF_IDX_W = 6
);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_fu_opcode;
  logic [1:0]           in_op1_sel;
  logic [1:0]           in_op2_sel;
  logic [DATA_W-1:0]    in_rs1_value;
  logic [DATA_W-1:0]    in_rs2_value;
  logic [DATA_W-1:0]    in_imm;
  logic [DATA_W-1:0]    in_pc;
  logic [ROB_IDX_W-1:0] in_rob_id;
  logic [PRF_IDX_W-1:0] in_rd_phy;
  logic [4:0]           in_rd_arch;

  logic                 cdb_valid;
  logic                 cdb_grant;
  logic [ROB_IDX_W-1:0] cdb_rob_id;
  logic [PRF_IDX_W-1:0] cdb_rd_phy;
  logic [4:0]           cdb_rd_arch;
  logic [DATA_W-1:0]    cdb_rd_value;

  modport master (
    output in_valid, in_fu_opcode, in_op1_sel, in_op2_sel,
           in_rs1_value, in_rs2_value, in_imm, in_pc,
           in_rob_id, in_rd_phy, in_rd_arch, cdb_grant,
    input  in_ready, cdb_valid, cdb_rob_id, cdb_rd_phy,
           cdb_rd_arch, cdb_rd_value
  );

  modport slave (
    input  in_valid, in_fu_opcode, in_op1_sel, in_op2_sel,
           in_rs1_value, in_rs2_value, in_imm, in_pc,
           in_rob_id, in_rd_phy, in_rd_arch, cdb_grant,
    output in_ready, cdb_valid, cdb_rob_id, cdb_rd_phy,
           cdb_rd_arch, cdb_rd_value
  );

endinterface

// File: rtl/fu_out_fifo.sv
// fu_out_fifo
//   Generic synchronous circular FIFO used to buffer functional-unit
//   completions. It is shared by the ALU unit and intended for later
//   mul/div units.
//   Ports:
//     clk, rst    - clock and synchronous active-high reset. Reset also
//                   zeroes the storage, so the head output reads 0.
//     flush       - empties the FIFO at the next edge. Storage is kept.
//     push        - write push_data at the tail. It is honoured when not
//                   full, or when full with a same-cycle pop.
//     pop         - advance the head. It is ignored while empty.
//     head_data   - entry at the head (registered storage, no bypass).
//     not_empty   - head_data is valid.
//     count       - number of stored entries.
module fu_out_fifo
  import fu_alu_pipe_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = 2,
  localparam int CNT_W = credit_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic             not_empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_ok;
  logic             push_ok;

  // The pointer wraps at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    pop_ok  = pop && (cnt_q != '0);
    // At full, a push is legal only because the same-cycle pop frees a slot.
    push_ok = push && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (push_ok) begin
      mem_d[tail_q] = push_data;
      tail_d        = ptr_inc(tail_q);
    end
    if (pop_ok) begin
      head_d = ptr_inc(head_q);
    end
    cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign not_empty = (cnt_q != '0);
  assign count     = cnt_q;

endmodule

// File: rtl/fu_alu_pipe.sv
// fu_alu_pipe
//   Integer ALU functional unit. It sits between the int RS issue register
//   and the CDB arbiter.
//   - The result is computed combinationally when an op is accepted.
//   - Result and tags then pass through LATENCY-1 retiming stages that
//     never stall.
//   - The entry lands in an output FIFO on the LATENCY-th edge after
//     accept, and the FIFO head drives the CDB.
//   - Overflow is prevented by crediting in_ready against the total
//     occupancy (in-flight stages plus FIFO entries).
//   Ports:
//     clk, rst - clock and synchronous active-high reset.
//     flush    - drops every in-flight and buffered op at the next edge.
//                An input presented in the same cycle is dropped too.
//     io       - slave side of fu_alu_pipe_if (issue + CDB).
module fu_alu_pipe
  import fu_alu_pipe_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int LATENCY       = 1,
  parameter int OUT_DEPTH     = 2,
  parameter int ROB_IDX_W     = 5,
  parameter int PRF_IDX_W     = 6,
  parameter int ENABLE_MINMAX = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  fu_alu_pipe_if.slave io
);

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_id;
    logic [PRF_IDX_W-1:0] rd_phy;
    logic [4:0]           rd_arch;
    logic [DATA_W-1:0]    rd_value;
  } fu_alu_pipe_entry_t;

  localparam int ENT_W = $bits(fu_alu_pipe_entry_t);
  localparam int CNT_W = credit_w(OUT_DEPTH);
  // With LATENCY=1 one dummy stage exists. It is never loaded, so its
  // valid bit stays 0 and adds nothing to the occupancy.
  localparam int NSTG  = (LATENCY > 1) ? LATENCY - 1 : 1;

  // ---------------- operand mux and ALU ----------------
  logic [DATA_W-1:0] op_a, op_b, result;
  logic [4:0]        shamt;
  logic              lt_s, lt_u;

  always_comb begin
    case (io.in_op1_sel)
      OP1_RS1: op_a = io.in_rs1_value;
      OP1_PC:  op_a = io.in_pc;
      default: op_a = '0;
    endcase
    case (io.in_op2_sel)
      OP2_RS2: op_b = io.in_rs2_value;
      OP2_IMM: op_b = io.in_imm;
      default: op_b = '0;
    endcase
    shamt = op_b[4:0];
    lt_s  = $signed(op_a) < $signed(op_b);
    lt_u  = op_a < op_b;
    case (io.in_fu_opcode)
      ALU_ADD:  result = op_a + op_b;
      ALU_SUB:  result = op_a - op_b;
      ALU_SLL:  result = op_a << shamt;
      ALU_SLT:  result = DATA_W'(lt_s);
      ALU_SLTU: result = DATA_W'(lt_u);
      ALU_XOR:  result = op_a ^ op_b;
      ALU_SRL:  result = op_a >> shamt;
      ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   result = op_a | op_b;
      ALU_AND:  result = op_a & op_b;
      ALU_MIN:  result = (ENABLE_MINMAX != 0) ? (lt_s ? op_a : op_b) : '0;
      ALU_MAX:  result = (ENABLE_MINMAX != 0) ? (lt_s ? op_b : op_a) : '0;
      ALU_MINU: result = (ENABLE_MINMAX != 0) ? (lt_u ? op_a : op_b) : '0;
      ALU_MAXU: result = (ENABLE_MINMAX != 0) ? (lt_u ? op_b : op_a) : '0;
      default:  result = '0;
    endcase
  end

  // ---------------- credit and accept ----------------
  logic [NSTG-1:0]    stg_vld_q, stg_vld_d;
  fu_alu_pipe_entry_t stg_ent_q [NSTG];
  fu_alu_pipe_entry_t stg_ent_d [NSTG];
  fu_alu_pipe_entry_t res_ent, push_ent, head_ent;
  logic [ENT_W-1:0]   fifo_head;
  logic [CNT_W-1:0]   fifo_count, occ;
  logic               fifo_ne, pop, accept, push;

  assign pop = fifo_ne && io.cdb_grant;

  // occ never exceeds OUT_DEPTH because in_ready withholds credit, so it
  // fits in CNT_W bits.
  always_comb begin
    occ = fifo_count;
    for (int i = 0; i < NSTG; i++) begin
      occ = occ + CNT_W'(stg_vld_q[i]);
    end
  end

  // pop is only possible when the FIFO holds an entry, so occ - pop
  // cannot underflow.
  assign io.in_ready = (occ - CNT_W'(pop)) < CNT_W'(OUT_DEPTH);
  assign accept      = io.in_valid && io.in_ready && !flush;

  always_comb begin
    res_ent.rob_id   = io.in_rob_id;
    res_ent.rd_phy   = io.in_rd_phy;
    res_ent.rd_arch  = io.in_rd_arch;
    res_ent.rd_value = result;
  end

  // ---------------- retiming stages ----------------
  always_comb begin
    stg_vld_d = '0;
    for (int i = 0; i < NSTG; i++) begin
      stg_ent_d[i] = stg_ent_q[i];
    end
    if (LATENCY == 1) begin
      push     = accept;
      push_ent = res_ent;
    end else begin
      stg_vld_d[0] = accept;
      stg_ent_d[0] = res_ent;
      for (int i = 1; i < NSTG; i++) begin
        stg_vld_d[i] = stg_vld_q[i-1];
        stg_ent_d[i] = stg_ent_q[i-1];
      end
      push     = stg_vld_q[NSTG-1];
      push_ent = stg_ent_q[NSTG-1];
    end
    if (flush) begin
      stg_vld_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld_q <= '0;
      for (int i = 0; i < NSTG; i++) begin
        stg_ent_q[i] <= '0;
      end
    end else begin
      stg_vld_q <= stg_vld_d;
      for (int i = 0; i < NSTG; i++) begin
        stg_ent_q[i] <= stg_ent_d[i];
      end
    end
  end

  // ---------------- output FIFO and CDB ----------------
  fu_out_fifo #(
    .W     (ENT_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_ent),
    .pop       (pop),
    .head_data (fifo_head),
    .not_empty (fifo_ne),
    .count     (fifo_count)
  );

  assign head_ent        = fifo_head;
  assign io.cdb_valid    = fifo_ne;
  assign io.cdb_rob_id   = head_ent.rob_id;
  assign io.cdb_rd_phy   = head_ent.rd_phy;
  assign io.cdb_rd_arch  = head_ent.rd_arch;
  assign io.cdb_rd_value = head_ent.rd_value;

endmodule

// File: tb/tb_fu_alu_pipe.sv
// tb_fu_alu_pipe
//   Four instances of the ALU unit cover the configurations of interest:
//     0: LATENCY=1 OUT_DEPTH=1 MINMAX on
//     1: LATENCY=3 OUT_DEPTH=2
//     2: LATENCY=2 OUT_DEPTH=2
//     3: LATENCY=1 OUT_DEPTH=3
//   Inputs come from drv[k]; observed outputs are gathered per instance.
module tb_fu_alu_pipe;
  import fu_alu_pipe_pkg::*;

  localparam int NDUT = 4;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 1;
      1:       return 3;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int depth_of(input int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rob;
    logic        grant;
    logic        flush;
  } drv_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  drv_t drv [NDUT];
  wire        rdy   [NDUT];
  wire        cv    [NDUT];
  wire [31:0] cval  [NDUT];
  wire [4:0]  crob  [NDUT];
  wire [5:0]  cphy  [NDUT];
  wire [4:0]  carch [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    fu_alu_pipe_if #(.DATA_W(32), .ROB_IDX_W(5), .PRF_IDX_W(6)) bus ();
    assign bus.in_valid     = drv[g].valid;
    assign bus.in_fu_opcode = drv[g].op;
    assign bus.in_op1_sel   = drv[g].s1;
    assign bus.in_op2_sel   = drv[g].s2;
    assign bus.in_rs1_value = drv[g].rs1;
    assign bus.in_rs2_value = drv[g].rs2;
    assign bus.in_imm       = drv[g].imm;
    assign bus.in_pc        = drv[g].pc;
    assign bus.in_rob_id    = drv[g].rob;
    assign bus.in_rd_phy    = {1'b1, drv[g].rob};
    assign bus.in_rd_arch   = ~drv[g].rob;
    assign bus.cdb_grant    = drv[g].grant;
    assign rdy[g]   = bus.in_ready;
    assign cv[g]    = bus.cdb_valid;
    assign cval[g]  = bus.cdb_rd_value;
    assign crob[g]  = bus.cdb_rob_id;
    assign cphy[g]  = bus.cdb_rd_phy;
    assign carch[g] = bus.cdb_rd_arch;

    fu_alu_pipe #(
      .DATA_W        (32),
      .LATENCY       (lat_of(g)),
      .OUT_DEPTH     (depth_of(g)),
      .ROB_IDX_W     (5),
      .PRF_IDX_W     (6),
      .ENABLE_MINMAX ((g == 0) ? 1 : 0)
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .flush (drv[g].flush),
      .io    (bus)
    );
  end

  // ---------------- scoreboard state ----------------
  int total;
  int bad;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // step: advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // settle: let combinational outputs follow the inputs just driven.
  task automatic settle();
    #1;
  endtask

  task automatic issue(input int k, input logic [3:0] op, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [4:0] rob);
    drv[k].valid = 1'b1;
    drv[k].op    = op;
    drv[k].s1    = s1;
    drv[k].s2    = s2;
    drv[k].rs1   = rs1;
    drv[k].rs2   = rs2;
    drv[k].imm   = imm;
    drv[k].pc    = pc;
    drv[k].rob   = rob;
  endtask

  task automatic idle(input int k);
    drv[k].valid = 1'b0;
  endtask

  // Issue one vector with grant held high and check it reaches the CDB
  // exactly lat cycles after issue.
  task automatic run_vec(input int k, input int lat, input string tag,
                         input vec_t v, input logic [4:0] rob);
    issue(k, v.op, v.s1, v.s2, v.rs1, v.rs2, v.imm, v.pc, rob);
    step();
    idle(k);
    for (int i = 1; i < lat; i++) step();
    settle();
    chk({tag, "_cv"}, 32'(cv[k]), 32'd1);
    chk({tag, "_val"}, cval[k], v.exp);
    chk({tag, "_rob"}, 32'(crob[k]), 32'(rob));
    step();
  endtask

  vec_t sweep [13];
  vec_t mm_off [2];

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_n;
    int pop_n;
    int mocc;
    logic exp_pop;
    logic exp_rdy;
    logic acc;
    logic [31:0] e;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int k = 0; k < NDUT; k++) drv[k] = '0;

    sweep[0]  = '{ALU_SRA,  OP1_RS1,  OP2_RS2,  32'h8000_0000, 32'd4,         32'd0, 32'd0,      32'hF800_0000};
    sweep[1]  = '{ALU_SLT,  OP1_RS1,  OP2_RS2,  32'hFFFF_FFFF, 32'd1,         32'd0, 32'd0,      32'd1};
    sweep[2]  = '{ALU_SLTU, OP1_RS1,  OP2_RS2,  32'hFFFF_FFFF, 32'd1,         32'd0, 32'd0,      32'd0};
    sweep[3]  = '{ALU_SLL,  OP1_RS1,  OP2_RS2,  32'd3,         32'h21,        32'd0, 32'd0,      32'd6};
    sweep[4]  = '{ALU_ADD,  OP1_PC,   OP2_IMM,  32'hDEAD,      32'hBEEF,      32'd4, 32'h1000,   32'h1004};
    sweep[5]  = '{ALU_MIN,  OP1_RS1,  OP2_RS2,  32'hFFFF_FFFE, 32'd3,         32'd0, 32'd0,      32'hFFFF_FFFE};
    sweep[6]  = '{ALU_MAXU, OP1_RS1,  OP2_RS2,  32'hFFFF_FFFE, 32'd3,         32'd0, 32'd0,      32'hFFFF_FFFE};
    sweep[7]  = '{ALU_XOR,  OP1_RS1,  OP2_RS2,  32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'd0,      32'h0000_0FF0};
    sweep[8]  = '{ALU_SRL,  OP1_RS1,  OP2_RS2,  32'h8000_0000, 32'd4,         32'd0, 32'd0,      32'h0800_0000};
    sweep[9]  = '{ALU_ADD,  OP1_ZERO, OP2_RS2,  32'd100,       32'd9,         32'd0, 32'd0,      32'd9};
    sweep[10] = '{4'd15,    OP1_RS1,  OP2_RS2,  32'd5,         32'd2,         32'd0, 32'd0,      32'd0};
    sweep[11] = '{ALU_ADD,  2'd3,     OP2_RS2,  32'd5,         32'd2,         32'd0, 32'd0,      32'd2};
    sweep[12] = '{ALU_AND,  OP1_RS1,  OP2_ZERO, 32'hFF,        32'h0F,        32'd0, 32'd0,      32'd0};
    mm_off[0] = '{ALU_MIN,  OP1_RS1,  OP2_RS2,  32'hFFFF_FFFE, 32'd3,         32'd0, 32'd0,      32'd0};
    mm_off[1] = '{ALU_MAXU, OP1_RS1,  OP2_RS2,  32'hFFFF_FFFE, 32'd3,         32'd0, 32'd0,      32'd0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    settle();

    // Reset state on every instance.
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst%0d_cv", k),   32'(cv[k]),    32'd0);
      chk($sformatf("rst%0d_val", k),  cval[k],       32'd0);
      chk($sformatf("rst%0d_rob", k),  32'(crob[k]),  32'd0);
      chk($sformatf("rst%0d_phy", k),  32'(cphy[k]),  32'd0);
      chk($sformatf("rst%0d_arch", k), 32'(carch[k]), 32'd0);
      chk($sformatf("rst%0d_rdy", k),  32'(rdy[k]),   32'd1);
    end

    // LATENCY=1, OUT_DEPTH=1, grant held: back-to-back ADD then SUB.
    drv[0].grant = 1'b1;
    issue(0, ALU_ADD, OP1_RS1, OP2_RS2, 32'd5, 32'd7, 32'd0, 32'd0, 5'd1);
    settle();
    chk("t1_rdy_c0", 32'(rdy[0]), 32'd1);
    step();
    issue(0, ALU_SUB, OP1_RS1, OP2_RS2, 32'd3, 32'd5, 32'd0, 32'd0, 5'd2);
    settle();
    chk("t1_rdy_c1",  32'(rdy[0]),   32'd1);
    chk("t1_cv_c1",   32'(cv[0]),    32'd1);
    chk("t1_val_c1",  cval[0],       32'h0000_000C);
    chk("t1_rob_c1",  32'(crob[0]),  32'd1);
    chk("t1_phy_c1",  32'(cphy[0]),  32'h21);
    chk("t1_arch_c1", 32'(carch[0]), 32'h1E);
    step();
    idle(0);
    settle();
    chk("t1_cv_c2",  32'(cv[0]),   32'd1);
    chk("t1_val_c2", cval[0],      32'hFFFF_FFFE);
    chk("t1_rob_c2", 32'(crob[0]), 32'd2);
    chk("t1_rdy_c2", 32'(rdy[0]),  32'd1);
    step();
    settle();
    chk("t1_cv_c3", 32'(cv[0]), 32'd0);
    step();

    // Op sweep on the MINMAX-enabled instance.
    for (int i = 0; i < 13; i++) begin
      run_vec(0, 1, $sformatf("sweep%0d", i), sweep[i], 5'(i + 3));
    end

    // MIN/MAX group disabled: results read as zero.
    drv[3].grant = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_vec(3, 1, $sformatf("mmoff%0d", i), mm_off[i], 5'(i + 20));
    end

    // LATENCY=3, OUT_DEPTH=2, grant low: credit stall, then release.
    drv[1].grant = 1'b0;
    issue(1, ALU_ADD, OP1_RS1, OP2_RS2, 32'd1, 32'd1, 32'd0, 32'd0, 5'd10);
    settle();
    chk("t2_rdy_c0", 32'(rdy[1]), 32'd1);
    step();
    issue(1, ALU_ADD, OP1_RS1, OP2_RS2, 32'd2, 32'd2, 32'd0, 32'd0, 5'd11);
    settle();
    chk("t2_rdy_c1", 32'(rdy[1]), 32'd1);
    step();
    issue(1, ALU_ADD, OP1_RS1, OP2_RS2, 32'd100, 32'd0, 32'd0, 32'd0, 5'd12);
    settle();
    chk("t2_rdy_c2", 32'(rdy[1]), 32'd0);
    chk("t2_cv_c2",  32'(cv[1]),  32'd0);
    step();
    issue(1, ALU_ADD, OP1_RS1, OP2_RS2, 32'd200, 32'd0, 32'd0, 32'd0, 5'd13);
    settle();
    chk("t2_rdy_c3", 32'(rdy[1]), 32'd0);
    chk("t2_cv_c3",  32'(cv[1]),  32'd1);
    chk("t2_val_c3", cval[1],     32'd2);
    step();
    idle(1);
    for (int c = 4; c < 6; c++) begin
      settle();
      chk($sformatf("t2_rdy_c%0d", c), 32'(rdy[1]), 32'd0);
      chk($sformatf("t2_val_c%0d", c), cval[1],     32'd2);
      step();
    end
    drv[1].grant = 1'b1;
    settle();
    chk("t2_rdy_c6", 32'(rdy[1]),  32'd1);
    chk("t2_cv_c6",  32'(cv[1]),   32'd1);
    chk("t2_val_c6", cval[1],      32'd2);
    chk("t2_rob_c6", 32'(crob[1]), 32'd10);
    step();
    settle();
    chk("t2_cv_c7",  32'(cv[1]),   32'd1);
    chk("t2_val_c7", cval[1],      32'd4);
    chk("t2_rob_c7", 32'(crob[1]), 32'd11);
    chk("t2_rdy_c7", 32'(rdy[1]),  32'd1);
    step();
    for (int c = 8; c < 12; c++) begin
      settle();
      chk($sformatf("t2_quiet_c%0d", c), 32'(cv[1]), 32'd0);
      step();
    end

    // LATENCY=2 flush: one op in the FIFO, one in the stage, input pending.
    drv[2].grant = 1'b0;
    issue(2, ALU_ADD, OP1_RS1, OP2_RS2, 32'h11, 32'd0, 32'd0, 32'd0, 5'd3);
    step();
    issue(2, ALU_ADD, OP1_RS1, OP2_RS2, 32'h22, 32'd0, 32'd0, 32'd0, 5'd4);
    settle();
    chk("t3_rdy_c1", 32'(rdy[2]), 32'd1);
    step();
    issue(2, ALU_ADD, OP1_RS1, OP2_RS2, 32'h33, 32'd0, 32'd0, 32'd0, 5'd5);
    drv[2].flush = 1'b1;
    settle();
    chk("t3_cv_pre",  32'(cv[2]),  32'd1);
    chk("t3_val_pre", cval[2],     32'h11);
    chk("t3_rdy_pre", 32'(rdy[2]), 32'd0);
    step();
    idle(2);
    drv[2].flush = 1'b0;
    drv[2].grant = 1'b1;
    settle();
    chk("t3_cv_post",  32'(cv[2]),  32'd0);
    chk("t3_rdy_post", 32'(rdy[2]), 32'd1);
    step();
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("t3_quiet%0d", c), 32'(cv[2]), 32'd0);
      step();
    end
    // A flush coinciding with a ready accept also drops that op.
    issue(2, ALU_ADD, OP1_RS1, OP2_RS2, 32'h99, 32'd0, 32'd0, 32'd0, 5'd6);
    drv[2].flush = 1'b1;
    settle();
    chk("t3_rdy_fl2", 32'(rdy[2]), 32'd1);
    step();
    idle(2);
    drv[2].flush = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("t3_drop%0d", c), 32'(cv[2]), 32'd0);
      step();
    end
    run_vec(2, 2, "t3_after", '{ALU_ADD, OP1_RS1, OP2_RS2, 32'h44, 32'd1, 32'd0, 32'd0, 32'h45}, 5'd7);

    // OUT_DEPTH=3 wrap: alternating grant, credit model, in-order scoreboard.
    acc_n = 0;
    pop_n = 0;
    mocc  = 0;
    exp_q.delete();
    for (int c = 0; c < 80 && (acc_n < 10 || exp_q.size() != 0); c++) begin
      drv[3].grant = (c % 2 == 1);
      if (acc_n < 10) begin
        issue(3, ALU_ADD, OP1_RS1, OP2_RS2, 32'h100 + 32'(acc_n), 32'd0, 32'd0, 32'd0, 5'(acc_n));
      end else begin
        idle(3);
      end
      settle();
      exp_pop = (mocc > 0) && drv[3].grant;
      exp_rdy = ((mocc - int'(exp_pop)) < 3);
      acc     = drv[3].valid && exp_rdy;
      chk($sformatf("t4_rdy_c%0d", c), 32'(rdy[3]), 32'(exp_rdy));
      chk($sformatf("t4_cv_c%0d", c),  32'(cv[3]),  32'(mocc > 0));
      if (exp_pop) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk($sformatf("t4_val_c%0d", c), cval[3], e);
        pop_n++;
      end
      if (acc) begin
        exp_q.push_back(32'h100 + 32'(acc_n));
        acc_n++;
      end
      mocc = mocc - int'(exp_pop) + int'(acc);
      step();
    end
    idle(3);
    chk("t4_accepted", 32'(acc_n), 32'd10);
    chk("t4_popped",   32'(pop_n), 32'd10);
    chk("t4_q_empty",  32'(exp_q.size()), 32'd0);

    // Synchronous reset mid-stream zeroes the payload and frees credit.
    drv[3].grant = 1'b0;
    issue(3, ALU_ADD, OP1_RS1, OP2_RS2, 32'h55, 32'd0, 32'd0, 32'd0, 5'd9);
    step();
    issue(3, ALU_ADD, OP1_RS1, OP2_RS2, 32'h66, 32'd0, 32'd0, 32'd0, 5'd10);
    step();
    idle(3);
    settle();
    chk("t5_cv_pre",  32'(cv[3]), 32'd1);
    chk("t5_val_pre", cval[3],    32'h55);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("t5_cv",   32'(cv[3]),    32'd0);
    chk("t5_val",  cval[3],       32'd0);
    chk("t5_rob",  32'(crob[3]),  32'd0);
    chk("t5_phy",  32'(cphy[3]),  32'd0);
    chk("t5_arch", 32'(carch[3]), 32'd0);
    chk("t5_rdy",  32'(rdy[3]),   32'd1);
    step();
    settle();
    chk("t5_cv_after", 32'(cv[3]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
